instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 Parameter INSTR_W, default 16, instruction width; opcode field is ir[INSTR_W-1:INSTR_W-5].
REQ-003 CLK  input  1  single clock; all state SHALL update on posedge CLK.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  begin execution at PC 0; sampled only in IDLE.
REQ-006 stall  input  1  freeze request from the datapath.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  ADDR_W  fetch address, equal to the PC.
REQ-009 imem_ack  input  1  fetch data valid; may assert in the same cycle as imem_req.
REQ-010 imem_data  input  INSTR_W  fetched instruction, valid when imem_ack=1.
REQ-011 ir  output  INSTR_W  registered current instruction.
REQ-012 opcode  output  5  ir opcode field, driven to the decoder.
REQ-013 alu_en  output  1  one-cycle pulse in EXEC.
REQ-014 wb_en  output  1  one-cycle pulse in WB; gates the register-file write.
REQ-015 busy  output  1  high in FETCH, DECODE, EXEC and WB.
REQ-016 halted  output  1  high in HALT.
REQ-017 illegal  output  1  one-cycle pulse on an undefined opcode.
REQ-018 retired_cnt  output  16  instructions completed; present only with SEQ_PERF_CNT_EN.

Function
REQ-019 States SHALL be IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-020 IDLE->FETCH SHALL occur when start=1; start SHALL be ignored in all other states.
REQ-021 FETCH SHALL drive imem_req=1 and imem_addr=PC, and SHALL wait any number of cycles for imem_ack.
REQ-022 On imem_ack in FETCH: ir<=imem_data; PC<=PC+1 modulo 2^ADDR_W (max wraps to 0); go to DECODE.
REQ-023 DECODE (one cycle): opcode 5'b11111 -> HALT; 5'b00010 (AR), 5'b01011 (T) or 5'b00001 (I) -> EXEC; any other opcode -> illegal=1 for that cycle, then FETCH with no EXEC and no WB.
REQ-024 EXEC SHALL assert alu_en for one cycle, then go to WB.
REQ-025 WB SHALL assert wb_en for one cycle, then go to FETCH.
REQ-026 With zero-wait memory, one instruction SHALL take exactly 4 cycles (FETCH, DECODE, EXEC, WB).
REQ-027 stall=1 in FETCH/DECODE/EXEC/WB SHALL hold state, PC and ir, and force alu_en=wb_en=0; imem_req stays high in FETCH and imem_ack is ignored; stall has priority over imem_ack.
REQ-028 After a stall releases, the held state SHALL execute exactly once, with no duplicate or lost pulses.
REQ-029 HALT SHALL be exited only by RST; start and stall SHALL have no effect in HALT.
REQ-030 All outputs SHALL be registered except opcode, which is taken combinationally from ir.

Reset
REQ-031 On RST=1 at a clock edge: state=IDLE, PC=0, ir=0, and imem_req, alu_en, wb_en, busy, halted, illegal and retired_cnt all 0.
REQ-032 RST SHALL override all other inputs in any state, including mid-instruction; an in-flight WB write SHALL not occur.

Configuration
REQ-033 Macro SEQ_PERF_CNT_EN, when defined: retired_cnt increments by 1 per WB cycle (not during a stall), wraps from 0xFFFF to 0, and holds in HALT.
REQ-034 Without SEQ_PERF_CNT_EN, the retired_cnt port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-035 A shared package SHALL hold the opcode constants (AR, T, I, HALT), the state encoding, and the ADDR_W/INSTR_W defaults.
REQ-036 One sub-module, pc_reg (load-zero, hold, increment-with-wrap), SHALL be instantiated; the FSM SHALL stay in instr_sequencer.

Verification
REQ-037 RST, start, zero-wait memory returning AR (00010) -> alu_en at cycle 3 and wb_en at cycle 4 after start; PC=1.
REQ-038 imem_ack delayed 3 cycles -> imem_req held high with imem_addr stable for 4 cycles, then DECODE.
REQ-039 Opcode 5'b10101 -> illegal pulses once, no alu_en or wb_en, next fetch from PC+1.
REQ-040 stall=1 for 2 cycles during EXEC -> alu_en low for those 2 cycles, then exactly one alu_en pulse and one wb_en pulse.
REQ-041 PC=0xFF fetch -> PC wraps to 0x00; HALT opcode -> halted=1, start ignored, RST returns to IDLE.
REQ-042 With SEQ_PERF_CNT_EN: 3 legal instructions, then RST asserted mid-EXEC of the 4th -> retired_cnt=3 before reset, 0 after, no wb_en.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared opcodes, state encoding and width defaults for instr_sequencer
package instr_sequencer_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;

    localparam logic [4:0] OP_AR   = 5'b00010;
    localparam logic [4:0] OP_T    = 5'b01011;
    localparam logic [4:0] OP_I    = 5'b00001;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    function automatic logic is_exec_op(input logic [4:0] op);
        return (op == OP_AR) || (op == OP_T) || (op == OP_I);
    endfunction

endpackage

// File: rtl/instr_sequencer_pc_reg.sv
// rtl/instr_sequencer_pc_reg.sv - program counter: load-zero, hold, increment with wrap
module pc_reg
    import instr_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_pc <= '0;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/exec/wb sequencer; SEQ_PERF_CNT_EN adds retired_cnt
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ir,
    output logic [4:0]         opcode,
    output logic               alu_en,
    output logic               wb_en,
    output logic               busy,
    output logic               halted,
`ifdef SEQ_PERF_CNT_EN
    output logic               illegal,
    output logic [15:0]        retired_cnt
`else
    output logic               illegal
`endif
);

    state_t               r_state;
    state_t               w_next;
    logic                 w_take;
    logic                 w_hold;
    logic [4:0]           w_data_op;
    logic [INSTR_W-1:0]   r_ir;
    logic                 r_imem_req;
    logic                 r_alu_en;
    logic                 r_wb_en;
    logic                 r_busy;
    logic                 r_halted;
    logic                 r_illegal;
    logic [ADDR_W-1:0]    w_pc;

    assign opcode    = r_ir[INSTR_W-1 -: 5];
    assign w_data_op = imem_data[INSTR_W-1 -: 5];

    // Stall freezes every busy state, and in FETCH it outranks imem_ack.
    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        w_hold = stall && (r_state inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_WB});
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_FETCH;
            ST_FETCH:  if (imem_ack) begin
                           w_next = ST_DECODE;
                           w_take = 1'b1;
                       end
            ST_DECODE: begin
                           if (opcode == OP_HALT)      w_next = ST_HALT;
                           else if (is_exec_op(opcode)) w_next = ST_EXEC;
                           else                         w_next = ST_FETCH;
                       end
            ST_EXEC:   w_next = ST_WB;
            ST_WB:     w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_IDLE;
        endcase
        if (w_hold) begin
            w_next = r_state;
            w_take = 1'b0;
        end
    end

    // Outputs are registered from the upcoming state so they line up with it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_ir       <= '0;
            r_imem_req <= 1'b0;
            r_alu_en   <= 1'b0;
            r_wb_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_next;
            if (w_take) r_ir <= imem_data;
            r_imem_req <= (w_next == ST_FETCH);
            r_alu_en   <= !w_hold && (w_next == ST_EXEC);
            r_wb_en    <= !w_hold && (w_next == ST_WB);
            r_busy     <= w_next inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_WB};
            r_halted   <= (w_next == ST_HALT);
            r_illegal  <= w_take && !is_exec_op(w_data_op) && (w_data_op != OP_HALT);
        end
    end

    pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
        .i_clk (CLK),
        .i_rst (RST),
        .i_clr ((r_state == ST_IDLE) && start),
        .i_inc (w_take),
        .o_pc  (w_pc)
    );

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] r_retired_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_retired_cnt <= '0;
        end else if (!w_hold && (w_next == ST_WB)) begin
            r_retired_cnt <= r_retired_cnt + 16'd1;
        end
    end

    assign retired_cnt = r_retired_cnt;
`endif

    assign imem_req  = r_imem_req;
    assign imem_addr = w_pc;
    assign ir        = r_ir;
    assign alu_en    = r_alu_en;
    assign wb_en     = r_wb_en;
    assign busy      = r_busy;
    assign halted    = r_halted;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized and directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    localparam logic [4:0] AR = 5'b00010, T = 5'b01011, I = 5'b00001, HLT = 5'b11111;
    localparam logic [4:0] BAD = 5'b10101;

    logic        clk, rst, start, stall, imem_ack;
    logic        imem_req, alu_en, wb_en, busy, halted, illegal;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data, ir;
    logic [4:0]  opcode;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0] retired_cnt;
`endif

    logic [15:0] mem [0:255];
    assign imem_data = mem[imem_addr];

    instr_sequencer dut (
        .CLK       (clk),
        .RST       (rst),
        .start     (start),
        .stall     (stall),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .ir        (ir),
        .opcode    (opcode),
        .alu_en    (alu_en),
        .wb_en     (wb_en),
        .busy      (busy),
        .halted    (halted),
`ifdef SEQ_PERF_CNT_EN
        .illegal   (illegal),
        .retired_cnt (retired_cnt)
`else
        .illegal   (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    function automatic logic [4:0] rand_op();
        logic [4:0] op;
        case ($urandom_range(0, 3))
            0: op = AR;
            1: op = T;
            2: op = I;
            default: begin
                op = 5'($urandom_range(0, 31));
                while (op == AR || op == T || op == I || op == HLT) op = 5'($urandom_range(0, 31));
            end
        endcase
        return op;
    endfunction

    // Memory responder with per-fetch wait count, plus random-phase stall and event scoreboard.
    logic        rand_mode = 1'b0;
    int          fix_delay = 0;
    int          cur_delay = 0;
    int          wcnt = 0;
    logic        prev_busy = 1'b0;
    logic [27:0] exp_q [$];
    logic [27:0] mon_got, mon_exp;

    always @(negedge clk) begin
        if (rand_mode) begin
            if (stall && prev_busy) check("stall_quiet", {alu_en, wb_en, illegal}, 3'b000);
            if (alu_en || wb_en || illegal) begin
                mon_got = {(illegal ? 4'd3 : (alu_en ? 4'd1 : 4'd2)), imem_addr, ir};
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    check("event", mon_got, mon_exp);
                end
            end
            stall = ($urandom_range(0, 3) == 0);
        end
        prev_busy = busy;
        if (imem_req) begin
            imem_ack = (wcnt >= cur_delay);
            wcnt++;
        end else begin
            imem_ack  = 1'b0;
            wcnt      = 0;
            cur_delay = rand_mode ? int'($urandom_range(0, 3)) : fix_delay;
        end
    end

    logic [3:0] b_exp [0:4];
    int na, nw, k;
    logic [4:0] op;

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; imem_ack = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = '0;
        next_cycle(); next_cycle();
        check("reset_flags", {imem_req, alu_en, wb_en, busy, halted, illegal}, 6'b0);
        check("reset_ir", ir, 16'h0);
        check("reset_pc", imem_addr, 8'h0);
        rst = 1'b0;

        // Random program: reference expects ALU+WB per legal op, one illegal pulse otherwise.
        for (int a = 0; a < 256; a++) mem[a] = {rand_op(), 11'($urandom)};
        for (int i = 0; i < 300; i++) begin
            logic [7:0] pa;
            pa = 8'((i + 1) % 256);
            op = mem[i % 256][15:11];
            if (op == AR || op == T || op == I) begin
                exp_q.push_back({4'd1, pa, mem[i % 256]});
                exp_q.push_back({4'd2, pa, mem[i % 256]});
            end else begin
                exp_q.push_back({4'd3, pa, mem[i % 256]});
            end
        end
        do_start();
        rand_mode = 1'b1;
        for (int c = 0; c < 20000 && exp_q.size() > 0; c++) next_cycle();
        check("rand_drain", exp_q.size(), 0);
        rand_mode = 1'b0;
        next_cycle();
        stall = 1'b0; rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("midrun_reset", {imem_req, alu_en, wb_en, busy, halted, illegal, imem_addr}, 14'b0);

        // Zero-wait AR: FETCH, DECODE, EXEC, WB then next FETCH.
        fix_delay = 0;
        mem[0] = {AR, 11'h5a3};
        mem[1] = {T, 11'h001};
        do_reset(); next_cycle();
        do_start();
        b_exp = '{4'b1001, 4'b0001, 4'b0101, 4'b0011, 4'b1001};
        for (int c = 0; c < 5; c++) begin
            check($sformatf("zw_cycle%0d", c + 1), {imem_req, alu_en, wb_en, busy}, b_exp[c]);
            if (c == 1) begin
                check("zw_ir", ir, mem[0]);
                check("zw_opcode", opcode, AR);
                check("zw_pc", imem_addr, 8'h01);
            end
            if (c < 4) next_cycle();
        end

        // Ack three cycles late: request and address held for four cycles.
        fix_delay = 3;
        do_reset(); next_cycle();
        do_start();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("wait_req%0d", c), {imem_req, busy, imem_addr}, {2'b11, 8'h00});
            next_cycle();
        end
        check("wait_decode", {imem_req, busy}, 2'b01);
        check("wait_ir", ir, mem[0]);

        // Undefined opcode: one illegal pulse, no ALU/WB, fetch from PC+1.
        fix_delay = 0;
        mem[0] = {BAD, 11'h123};
        do_reset(); next_cycle();
        do_start();
        next_cycle();
        check("ill_pulse", {illegal, alu_en, wb_en}, 3'b100);
        next_cycle();
        check("ill_refetch", {illegal, alu_en, wb_en, imem_req}, 4'b0001);
        check("ill_pc", imem_addr, 8'h01);

        // Stall two cycles in EXEC.
        mem[0] = {I, 11'h042};
        mem[1] = {BAD, 11'h000};
        do_reset(); next_cycle();
        do_start();
        next_cycle(); next_cycle();
        check("stall_exec_alu", alu_en, 1'b1);
        na = 1; nw = 0;
        stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            check($sformatf("stall_hold%0d", c), {alu_en, wb_en}, 2'b00);
        end
        stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            na += int'(alu_en); nw += int'(wb_en);
        end
        check("stall_alu_count", na, 1);
        check("stall_wb_count", nw, 1);

        // PC wrap from 0xFF and HALT behaviour.
        for (int a = 0; a < 256; a++) mem[a] = {BAD, 11'h0};
        do_reset(); next_cycle();
        do_start();
        for (k = 0; k < 1000; k++) begin
            if (imem_req && imem_addr == 8'hFF) break;
            next_cycle();
        end
        check("wrap_reach_ff", {imem_req, imem_addr}, {1'b1, 8'hFF});
        mem[0] = {HLT, 11'h0};
        for (k = 0; k < 10; k++) begin
            if (imem_req && imem_addr != 8'hFF) break;
            next_cycle();
        end
        check("wrap_to_zero", {imem_req, imem_addr}, {1'b1, 8'h00});
        for (k = 0; k < 10; k++) begin
            if (halted) break;
            next_cycle();
        end
        check("halt_entered", {halted, busy}, 2'b10);
        start = 1'b1; stall = 1'b1;
        next_cycle(); next_cycle(); next_cycle();
        check("halt_sticky", {halted, busy, imem_req, imem_addr}, {3'b100, 8'h01});
        start = 1'b0; stall = 1'b0;
        do_reset();
        check("halt_reset", {halted, busy, imem_addr}, {2'b00, 8'h00});
        do_start();
        check("halt_restart", {imem_req, imem_addr}, {1'b1, 8'h00});

        // Reset during EXEC of the 4th instruction kills its write-back.
        for (int a = 0; a < 8; a++) mem[a] = {AR, 11'(a)};
        do_reset(); next_cycle();
        do_start();
        na = 0; nw = 0;
        for (k = 0; k < 100; k++) begin
            next_cycle();
            nw += int'(wb_en); na += int'(alu_en);
            if (na == 4) break;
        end
        check("rst4_alu_seen", na, 4);
        check("rst4_wb_before", nw, 3);
`ifdef SEQ_PERF_CNT_EN
        check("retired_before", retired_cnt, 16'd3);
`endif
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
`ifdef SEQ_PERF_CNT_EN
        check("retired_after", retired_cnt, 16'd0);
`endif
        nw = int'(wb_en);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            nw += int'(wb_en) + int'(busy);
        end
        check("rst4_no_wb", nw, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
